// File: rtl/instr_fetch_mem_if.sv
// rtl/instr_fetch_mem_if.sv - fetch request/response handshake bundle
// master is the CPU fetch stage, slave is the instruction memory.
interface instr_fetch_mem_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int INSTR_BYTES = 2
);
   logic                     req_valid;
   logic                     req_ready;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [8*INSTR_BYTES-1:0] resp_instr;
   logic                     resp_fault;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_instr, resp_fault
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_instr, resp_fault
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - byte-addressable instruction memory, big-endian fetch, one-deep response stage
// Optional range fault: define INSTR_MEM_BOUNDS_CHECK_EN; otherwise byte indices wrap modulo DEPTH_BYTES.
module instr_fetch_mem #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH_BYTES = 1024,
   parameter int INSTR_BYTES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   instr_fetch_mem_if.slave      fetch,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [7:0]            load_data
);
   localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic {EMPTY, FULL} state_t;

   logic [7:0]               mem [DEPTH_BYTES];
   state_t                   state;
   logic [8*INSTR_BYTES-1:0] next_instr;
   logic [8*INSTR_BYTES-1:0] instr_q;
   logic                     next_fault;
   logic                     fault_q;
   logic                     accept;

   assign fetch.resp_valid = (state == FULL);
   assign fetch.req_ready  = (state == EMPTY) || fetch.resp_ready;
   assign fetch.resp_instr = instr_q;
   assign fetch.resp_fault = fault_q;
   assign accept           = fetch.req_valid && fetch.req_ready;

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
   localparam logic [ADDR_WIDTH:0] MAX_FIRST = (ADDR_WIDTH+1)'(DEPTH_BYTES - INSTR_BYTES);
`endif

   // Reads see the array before this edge's load, which gives read-before-write on collisions.
   always_comb begin
      next_instr = '0;
      next_fault = 1'b0;
      for (int i = 0; i < INSTR_BYTES; i++) begin
         next_instr[8*(INSTR_BYTES-1-i) +: 8] =
            mem[IDX_W'({1'b0, fetch.req_addr} + (ADDR_WIDTH+1)'(i))];
      end
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
      next_fault = ({1'b0, fetch.req_addr} > MAX_FIRST);
      if (next_fault) begin
         next_instr = '0;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (load_en) begin
         mem[IDX_W'(load_addr)] <= load_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         instr_q <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state   <= FULL;
                  instr_q <= next_instr;
                  fault_q <= next_fault;
               end
            end
            FULL: begin
               if (accept) begin
                  instr_q <= next_instr;
                  fault_q <= next_fault;
               end else if (fetch.resp_ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - randomized self-checking bench for instr_fetch_mem
// Reference model: a plain byte array plus the response rules, advanced once per clock.
module tb_instr_fetch_mem;
   localparam int AW    = 16;
   localparam int DEPTH = 1024;
   localparam int IB    = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;

   instr_fetch_mem_if #(.ADDR_WIDTH(AW), .INSTR_BYTES(IB)) fetch_bus ();

   instr_fetch_mem #(.ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .INSTR_BYTES(IB)) dut (
      .clock     (clock),
      .reset     (reset),
      .fetch     (fetch_bus),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
   );

   always #5 clock = ~clock;

   logic [7:0]      model_mem [DEPTH];
   logic            exp_valid = 1'b0;
   logic [8*IB-1:0] exp_instr = '0;
   logic            exp_fault = 1'b0;
   int              total = 0;
   int              bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {instr, fault} for a request at addr, from the model array.
   function automatic logic [8*IB:0] ref_fetch(input logic [AW-1:0] addr);
      logic [8*IB-1:0] ins;
      int a;
      a   = int'(addr);
      ins = '0;
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
      if (a > DEPTH - IB) return {{(8*IB){1'b0}}, 1'b1};
`endif
      for (int i = 0; i < IB; i++) ins = {ins[8*IB-9:0], model_mem[(a + i) % DEPTH]};
      return {ins, 1'b0};
   endfunction

   // Drive one cycle's inputs at the negedge, advance the model, check at the next negedge.
   task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic le, input logic [AW-1:0] la, input logic [7:0] ld);
      logic acc;
      fetch_bus.req_valid  = rv;
      fetch_bus.req_addr   = ra;
      fetch_bus.resp_ready = rr;
      load_en   = le;
      load_addr = la;
      load_data = ld;
      acc = rv && (!exp_valid || rr);
      if (acc) begin
         {exp_instr, exp_fault} = ref_fetch(ra);
         exp_valid = 1'b1;
      end else if (rr) begin
         exp_valid = 1'b0;
      end
      if (le) model_mem[int'(la) % DEPTH] = ld;
      @(posedge clock);
      @(negedge clock);
      chk("resp_valid", 64'(fetch_bus.resp_valid), 64'(exp_valid));
      chk("resp_instr", 64'(fetch_bus.resp_instr), 64'(exp_instr));
      chk("resp_fault", 64'(fetch_bus.resp_fault), 64'(exp_fault));
      chk("req_ready",  64'(fetch_bus.req_ready),  64'(!exp_valid || rr));
   endtask

   initial begin
      logic [AW-1:0] ra;
      fetch_bus.req_valid  = 1'b0;
      fetch_bus.req_addr   = '0;
      fetch_bus.resp_ready = 1'b1;
      repeat (2) @(negedge clock);
      chk("reset_valid", 64'(fetch_bus.resp_valid), 64'd0);
      chk("reset_instr", 64'(fetch_bus.resp_instr), 64'd0);
      chk("reset_fault", 64'(fetch_bus.resp_fault), 64'd0);
      chk("reset_ready", 64'(fetch_bus.req_ready),  64'd1);
      reset = 1'b0;

      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b1, AW'(i), 8'($urandom_range(0, 255)));

      step(1'b0, '0, 1'b1, 1'b1, 16'd0, 8'h20);
      step(1'b0, '0, 1'b1, 1'b1, 16'd1, 8'h12);
      step(1'b0, '0, 1'b1, 1'b1, 16'd2, 8'h34);
      step(1'b0, '0, 1'b1, 1'b1, 16'd3, 8'h56);
      step(1'b1, 16'd0, 1'b1, 1'b0, '0, '0);
      chk("basic_addr0", 64'(fetch_bus.resp_instr), 64'h2012);
      step(1'b1, 16'd1, 1'b1, 1'b0, '0, '0);
      chk("basic_addr1", 64'(fetch_bus.resp_instr), 64'h1234);

      step(1'b1, 16'd0, 1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'd2, 1'b0, 1'b0, '0, '0);
         chk("stall_ready", 64'(fetch_bus.req_ready), 64'd0);
         chk("stall_hold",  64'(fetch_bus.resp_instr), 64'h2012);
      end
      step(1'b1, 16'd2, 1'b1, 1'b0, '0, '0);
      chk("stall_release", 64'(fetch_bus.resp_instr), 64'h3456);

      step(1'b0, '0, 1'b1, 1'b1, 16'd1023, 8'hAB);
      step(1'b1, 16'd1023, 1'b1, 1'b0, '0, '0);
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
      chk("bound_1023_fault", 64'(fetch_bus.resp_fault), 64'd1);
      chk("bound_1023_instr", 64'(fetch_bus.resp_instr), 64'd0);
`else
      chk("wrap_1023", 64'(fetch_bus.resp_instr), 64'hAB20);
`endif
      step(1'b1, 16'hFFFF, 1'b1, 1'b0, '0, '0);
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
      chk("bound_ffff_fault", 64'(fetch_bus.resp_fault), 64'd1);
`else
      chk("wrap_ffff", 64'(fetch_bus.resp_instr), 64'hAB20);
`endif
      step(1'b1, 16'd1022, 1'b1, 1'b0, '0, '0);
      chk("bound_1022_fault", 64'(fetch_bus.resp_fault), 64'd0);

      step(1'b0, '0, 1'b1, 1'b1, 16'd4, 8'h11);
      step(1'b1, 16'd4, 1'b1, 1'b1, 16'd4, 8'h99);
      chk("collide_old", 64'(fetch_bus.resp_instr[15:8]), 64'h11);
      step(1'b1, 16'd4, 1'b1, 1'b0, '0, '0);
      chk("collide_new", 64'(fetch_bus.resp_instr[15:8]), 64'h99);

      // Asynchronous reset while a response is pending; the request seen under reset is dropped.
      fetch_bus.req_valid  = 1'b1;
      fetch_bus.resp_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("areset_valid", 64'(fetch_bus.resp_valid), 64'd0);
      chk("areset_instr", 64'(fetch_bus.resp_instr), 64'd0);
      chk("areset_fault", 64'(fetch_bus.resp_fault), 64'd0);
      chk("areset_ready", 64'(fetch_bus.req_ready),  64'd1);
      @(negedge clock);
      chk("areset_discard", 64'(fetch_bus.resp_valid), 64'd0);
      reset     = 1'b0;
      exp_valid = 1'b0;
      exp_instr = '0;
      exp_fault = 1'b0;

      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = AW'(DEPTH - 4 + $urandom_range(0, 3));
            1:       ra = AW'($urandom_range(0, 65535));
            default: ra = AW'($urandom_range(0, DEPTH - 1));
         endcase
         step(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 0) ? ra : AW'($urandom_range(0, 65535)),
              8'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
